ahb_timer_peripheral: RTL and testbench
=======================================

Name: ahb_timer_peripheral

Overview:
- Register-mapped down-counting timer.
- Sits directly downstream of the AHB slave interface. It consumes peripheral_we, peripheral_re, Addr, size and wd_data from that interface and returns peripheral_rd_data, peripheral_ready and peripheral_response to it.
- Provides a prescaled 32-bit down counter with optional auto-reload and a level interrupt.
- Every access completes in one cycle, with zero wait states.

Parameters:
- BASE_ADDR, 32'h4000_0000: peripheral base address. The block is selected when Addr[31:8] == BASE_ADDR[31:8].
- PRESCALE_W, 16: width of the prescaler register and the prescaler counter.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous, active-high reset.
- peripheral_we  in  1  write strobe for the data phase currently on the bus.
- peripheral_re  in  1  read strobe for the data phase currently on the bus.
- Addr  in  32  byte address of the access.
- size  in  2  transfer size: 00 byte, 01 halfword, 10 word, 11 illegal.
- wd_data  in  32  write data, placed on its natural byte lanes.
- peripheral_rd_data  out  32  read data.
- peripheral_ready  out  1  transfer-complete indication.
- peripheral_response  out  1  1 = ERROR for the current access.
- timer_irq  out  1  level interrupt.

Behaviour:
- Reset (HRESET high, asynchronous): CTRL, LOAD, VALUE, PRESCALE, STATUS and the prescaler counter all go to 0.
  - Outputs during reset: peripheral_ready=1, peripheral_response=0, peripheral_rd_data=0, timer_irq=0.
  - Reset mid-count aborts the count immediately. No expiry is recorded.
- Register map (offset = Addr[7:0]):
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN. Other bits read as 0.
  - 0x04 LOAD: read/write, 32 bits.
  - 0x08 VALUE: read-only.
  - 0x0C PRESCALE: read/write, PRESCALE_W bits, upper bits read as 0.
  - 0x10 STATUS: bit0 EXPIRED, write-1-to-clear.
- peripheral_ready is tied to 1 after reset. It must never depend on peripheral_we or peripheral_re, because upstream gates those strobes with ready.
- Write path:
  - A write takes effect at the HCLK edge that ends the cycle in which peripheral_we=1.
  - Byte lanes are selected from size and Addr[1:0]: byte writes lane Addr[1:0], halfword writes lanes {Addr[1],0}+0/1, word writes all lanes.
- Read path:
  - peripheral_rd_data is combinational. It is the full 32-bit register word at the addressed offset when peripheral_re=1, otherwise 0.
  - A read returns the value as it was before the edge.
- Error: peripheral_response is combinational, equal to (we|re) && illegal, in the same cycle. The access is ignored (no state change, read data 0). An access is illegal if any of the following holds:
  - Addr[31:8] does not match the base address.
  - The offset is unmapped (not 0x00–0x10 word-aligned).
  - size==11.
  - The access is misaligned: a halfword with Addr[0]=1, or a word with Addr[1:0]!=0.
  - It is a write to VALUE.
- Counting:
  - When EN=1, the prescaler counter increments each cycle. When it equals PRESCALE, it wraps to 0 and issues a one-cycle tick. PRESCALE=0 gives a tick every cycle.
  - On a tick with VALUE!=0, VALUE decrements by 1.
  - On a tick with VALUE==0, EXPIRED is set. Then:
    - If AUTO_RELOAD=1, VALUE loads from LOAD and counting continues.
    - If AUTO_RELOAD=0, EN clears and VALUE stays 0.
- LOAD write: also copies the written LOAD value into VALUE and clears the prescaler counter at the same edge. Counting resumes from that point.
- CTRL write that changes EN from 0 to 1 clears the prescaler counter.
- Simultaneous events:
  - A W1C to STATUS in the same cycle as an expiry: the set wins, so EXPIRED=1.
  - A LOAD write in the same cycle as a tick: the LOAD write wins.
  - A CTRL write clearing EN in the same cycle as a tick: the tick is discarded.
- timer_irq = EXPIRED & IRQ_EN, driven from register outputs (no combinational path from the bus inputs).

Decomposition:
- Shared package timer_pkg:
  - register offset constants;
  - CTRL bit-index constants;
  - size encoding constants;
  - an error/okay response constant.
- One sub-module, timer_core: the prescaler counter, the VALUE down counter, the reload logic and the tick/expiry generation.
  - Inputs from the register block: en, auto_reload, prescale, load strobe and load value.
  - Outputs: value, expire pulse, en_clear pulse.

Test Plan:
- Reset, then write CTRL=0x0000_0007 and read it back -> rd_data=0x0000_0007, response=0, ready=1 on every cycle.
- LOAD=3, PRESCALE=0, CTRL=0x1 -> VALUE reads 3,2,1,0 on successive cycles. EXPIRED=1 on the next cycle, EN self-clears, VALUE holds 0.
- LOAD=2, PRESCALE=1, CTRL=0x7 -> VALUE decrements every 2 cycles, reloads to 2 after reaching 0, timer_irq=1 after the first expiry. A STATUS write of 0x1 drops timer_irq on the next cycle.
- Error cases, each giving response=1 in the same cycle with no register change:
  - write to 0x4000_0008;
  - word read at 0x4000_0002;
  - access at offset 0x14;
  - access at Addr 0x5000_0000;
  - access with size=11.
- Byte write of 0xAB at offset 0x05 (wd_data=0x0000_AB00) on LOAD=0x1122_3344 -> LOAD reads back 0x1122_AB44.
- Expiry in the same cycle as a STATUS W1C -> EXPIRED stays 1. Assert HRESET mid-count -> all registers are 0 and timer_irq=0 immediately, without waiting for HCLK.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: definitions shared by the register-mapped timer.
//   - register offsets (byte offset within the 256-byte peripheral window)
//   - CTRL bit indices
//   - AHB transfer size encodings
//   - bus response encodings
//   - lane_mask / merge_lanes helpers for byte-lane writes
package timer_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_LOAD     = 8'h04;
    localparam logic [7:0] OFF_VALUE    = 8'h08;
    localparam logic [7:0] OFF_PRESCALE = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;
    localparam logic [7:0] OFF_LAST     = OFF_STATUS;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_W           = 3;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    // Byte lanes touched by an access of the given size at address bits [1:0].
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] m;
        case (size)
            SIZE_BYTE: m = 4'b0001 << a;
            SIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: m = 4'b1111;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replace the enabled byte lanes of 'old' with those of 'wd'.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = m[i] ? wd[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_core.sv
// timer_core: prescaler counter, VALUE down counter, reload and expiry.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   en_i              effective enable (already masked by a same-cycle EN clear)
//   auto_reload_i     reload VALUE from load_value_i on expiry
//   prescale_i        prescaler terminal count (0 = tick every cycle)
//   load_i            LOAD register write strobe this cycle
//   load_value_i      LOAD contents as of the next edge (new value when load_i)
//   value_o           current VALUE
//   expire_o          one-cycle pulse: tick seen while VALUE == 0
//   en_clear_o        one-cycle pulse: expiry without auto-reload, EN must drop
module timer_core #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  auto_reload_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  load_i,
    input  logic [31:0]           load_value_i,
    output logic [31:0]           value_o,
    output logic                  expire_o,
    output logic                  en_clear_o
);

    logic [PRESCALE_W-1:0] psc_q, psc_d;
    logic [31:0]           value_q, value_d;
    logic                  tick;

    // A LOAD write restarts the count, so it swallows any tick of the same cycle.
    assign tick = en_i && (psc_q == prescale_i) && !load_i;

    always_comb begin
        psc_d   = psc_q + PRESCALE_W'(1);
        value_d = value_q;
        // Holding the prescaler at 0 while disabled makes an EN 0->1 start from 0.
        if (load_i || !en_i || tick) begin
            psc_d = '0;
        end
        if (load_i) begin
            value_d = load_value_i;
        end else if (tick) begin
            if (value_q != 32'd0) begin
                value_d = value_q - 32'd1;
            end else if (auto_reload_i) begin
                value_d = load_value_i;
            end else begin
                value_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            psc_q   <= '0;
            value_q <= '0;
        end else begin
            psc_q   <= psc_d;
            value_q <= value_d;
        end
    end

    assign value_o    = value_q;
    assign expire_o   = tick && (value_q == 32'd0);
    assign en_clear_o = expire_o && !auto_reload_i;

endmodule

// File: rtl/ahb_timer_peripheral.sv
// ahb_timer_peripheral: register block of a prescaled 32-bit down-counting timer,
// fed by the AHB slave data-phase strobes.
// Ports:
//   HCLK, HRESET          clock, asynchronous active-high reset
//   peripheral_we/_re     write/read strobes for the current data phase
//   Addr, size, wd_data   byte address, transfer size, lane-aligned write data
//   peripheral_rd_data    combinational read data (0 unless a legal read)
//   peripheral_ready      always 1: every access completes in its own cycle
//   peripheral_response   1 = ERROR for the current access (combinational)
//   timer_irq             EXPIRED & IRQ_EN, from registers only
//
// Handshake: there are no wait states. An access is accepted in the cycle its
// strobe is high; writes commit at the closing HCLK edge, reads and the error
// response are valid combinationally within that same cycle. Ready never looks
// at the strobes because upstream qualifies the strobes with ready.
module ahb_timer_peripheral
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        peripheral_we,
    input  logic        peripheral_re,
    input  logic [31:0] Addr,
    input  logic [1:0]  size,
    input  logic [31:0] wd_data,
    output logic [31:0] peripheral_rd_data,
    output logic        peripheral_ready,
    output logic        peripheral_response,
    output logic        timer_irq
);

    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [31:0]           load_q, load_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  expired_q, expired_d;

    logic [31:0] value;
    logic        expire, en_clear, en_eff;

    logic [7:0]  word_off;
    logic [3:0]  mask;
    logic        sel, mapped, misaligned, illegal, wr_ok, rd_ok;
    logic [31:0] reg_word, wr_merged;
    logic        ctrl_wr, load_wr, prescale_wr, status_wr;

    // ---------------- access decode ----------------
    assign word_off   = {Addr[7:2], 2'b00};
    assign sel        = (Addr[31:8] == BASE_ADDR[31:8]);
    assign mapped     = (word_off <= OFF_LAST);
    assign misaligned = ((size == SIZE_HALF) && Addr[0]) ||
                        ((size == SIZE_WORD) && (Addr[1:0] != 2'b00));
    assign illegal    = !sel || !mapped || (size == SIZE_BAD) || misaligned ||
                        (peripheral_we && (word_off == OFF_VALUE));
    assign wr_ok      = peripheral_we && !illegal;
    assign rd_ok      = peripheral_re && !illegal;
    assign mask       = lane_mask(size, Addr[1:0]);

    always_comb begin
        reg_word = '0;
        case (word_off)
            OFF_CTRL:     reg_word = 32'(ctrl_q);
            OFF_LOAD:     reg_word = load_q;
            OFF_VALUE:    reg_word = value;
            OFF_PRESCALE: reg_word = 32'(prescale_q);
            OFF_STATUS:   reg_word = {31'd0, expired_q};
            default:      reg_word = '0;
        endcase
    end

    // Partial writes keep the untouched lanes of the addressed register.
    assign wr_merged   = merge_lanes(reg_word, wd_data, mask);
    assign ctrl_wr     = wr_ok && (word_off == OFF_CTRL);
    assign load_wr     = wr_ok && (word_off == OFF_LOAD);
    assign prescale_wr = wr_ok && (word_off == OFF_PRESCALE);
    assign status_wr   = wr_ok && (word_off == OFF_STATUS);

    // A CTRL write that clears EN discards the tick of the same cycle.
    assign en_eff = ctrl_q[CTRL_EN] && !(ctrl_wr && !wr_merged[CTRL_EN]);

    always_comb begin
        ctrl_d     = ctrl_q;
        load_d     = load_q;
        prescale_d = prescale_q;
        expired_d  = expired_q;
        if (ctrl_wr) begin
            ctrl_d = wr_merged[CTRL_W-1:0];
        end else if (en_clear) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end
        if (load_wr) begin
            load_d = wr_merged;
        end
        if (prescale_wr) begin
            prescale_d = wr_merged[PRESCALE_W-1:0];
        end
        // Expiry takes priority over a same-cycle write-1-to-clear.
        if (expire) begin
            expired_d = 1'b1;
        end else if (status_wr && mask[0] && wd_data[0]) begin
            expired_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ctrl_q     <= '0;
            load_q     <= '0;
            prescale_q <= '0;
            expired_q  <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            prescale_q <= prescale_d;
            expired_q  <= expired_d;
        end
    end

    timer_core #(
        .PRESCALE_W (PRESCALE_W)
    ) u_core (
        .clk_i         (HCLK),
        .rst_i         (HRESET),
        .en_i          (en_eff),
        .auto_reload_i (ctrl_q[CTRL_AUTO_RELOAD]),
        .prescale_i    (prescale_q),
        .load_i        (load_wr),
        .load_value_i  (load_d),
        .value_o       (value),
        .expire_o      (expire),
        .en_clear_o    (en_clear)
    );

    // ---------------- bus outputs ----------------
    assign peripheral_ready    = 1'b1;
    assign peripheral_response = (!HRESET && (peripheral_we || peripheral_re) && illegal)
                                 ? RESP_ERROR : RESP_OKAY;
    assign peripheral_rd_data  = (!HRESET && rd_ok) ? reg_word : 32'd0;
    assign timer_irq           = expired_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_ahb_timer_peripheral.sv
`timescale 1ns/1ps
module tb_ahb_timer_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [1:0]  SZ_B = 2'b00;
  localparam logic [1:0]  SZ_H = 2'b01;
  localparam logic [1:0]  SZ_W = 2'b10;
  localparam logic [1:0]  SZ_X = 2'b11;
  localparam logic [31:0] O_CTRL = 32'h00;
  localparam logic [31:0] O_LOAD = 32'h04;
  localparam logic [31:0] O_VAL  = 32'h08;
  localparam logic [31:0] O_PSC  = 32'h0C;
  localparam logic [31:0] O_STAT = 32'h10;

  // ---------------- clock / reset ----------------
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        peripheral_we;
  logic        peripheral_re;
  logic [31:0] Addr;
  logic [1:0]  size;
  logic [31:0] wd_data;
  logic [31:0] peripheral_rd_data;
  logic        peripheral_ready;
  logic        peripheral_response;
  logic        timer_irq;

  always #5 HCLK = ~HCLK;

  ahb_timer_peripheral #(
    .BASE_ADDR  (32'h4000_0000),
    .PRESCALE_W (16)
  ) dut (
    .HCLK                (HCLK),
    .HRESET              (HRESET),
    .peripheral_we       (peripheral_we),
    .peripheral_re       (peripheral_re),
    .Addr                (Addr),
    .size                (size),
    .wd_data             (wd_data),
    .peripheral_rd_data  (peripheral_rd_data),
    .peripheral_ready    (peripheral_ready),
    .peripheral_response (peripheral_response),
    .timer_irq           (timer_irq)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One bus cycle, negedge to negedge; outputs sampled 1ns after the drive.
  task automatic acc(input string tag, input logic we, input logic re, input logic [31:0] addr,
                     input logic [1:0] sz, input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_resp);
    @(negedge HCLK);
    peripheral_we = we;
    peripheral_re = re;
    Addr          = addr;
    size          = sz;
    wd_data       = wd;
    exp_q.push_back(exp_rd);
    #1;
    check_val({tag, ".rd"}, peripheral_rd_data, exp_q.pop_front());
    check_val({tag, ".resp"}, {31'd0, peripheral_response}, {31'd0, exp_resp});
    check_val({tag, ".ready"}, {31'd0, peripheral_ready}, 32'd1);
  endtask

  task automatic wr(input string tag, input logic [31:0] off, input logic [31:0] d);
    acc(tag, 1'b1, 1'b0, BASE + off, SZ_W, d, 32'd0, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
    acc(tag, 1'b0, 1'b1, BASE + off, SZ_W, 32'd0, exp, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge HCLK);
      peripheral_we = 1'b0;
      peripheral_re = 1'b0;
      Addr          = 32'd0;
      size          = SZ_W;
      wd_data       = 32'd0;
    end
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check_val(tag, {31'd0, timer_irq}, {31'd0, exp});
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] t3_val [7] = '{32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd2};
  logic        t3_irq [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] off_tab [5] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};

  initial begin
    HRESET        = 1'b1;
    peripheral_we = 1'b0;
    peripheral_re = 1'b1;
    Addr          = BASE + O_LOAD;
    size          = SZ_W;
    wd_data       = 32'd0;
    repeat (2) @(negedge HCLK);
    #1;
    check_val("rst.ready", {31'd0, peripheral_ready}, 32'd1);
    check_val("rst.resp", {31'd0, peripheral_response}, 32'd0);
    check_val("rst.rd", peripheral_rd_data, 32'd0);
    chk_irq("rst.irq", 1'b0);
    @(negedge HCLK);
    HRESET = 1'b0;
    idle(1);
    for (int i = 0; i < 5; i++) rd($sformatf("rst_reg%0d", i), off_tab[i], 32'd0);

    // CTRL write / readback
    wr("t1.wr_ctrl", O_CTRL, 32'h0000_0007);
    rd("t1.rd_ctrl", O_CTRL, 32'h0000_0007);
    wr("t1.ctrl0", O_CTRL, 32'd0);
    wr("t1.clr", O_STAT, 32'd1);
    rd("t1.stat", O_STAT, 32'd0);

    // one-shot, prescale 0
    wr("t2.psc", O_PSC, 32'd0);
    wr("t2.load", O_LOAD, 32'd3);
    wr("t2.ctrl", O_CTRL, 32'h1);
    rd("t2.v3", O_VAL, 32'd3);
    rd("t2.v2", O_VAL, 32'd2);
    rd("t2.v1", O_VAL, 32'd1);
    rd("t2.v0", O_VAL, 32'd0);
    rd("t2.stat", O_STAT, 32'd1);
    rd("t2.ctrl_selfclr", O_CTRL, 32'd0);
    rd("t2.vhold", O_VAL, 32'd0);
    rd("t2.vhold2", O_VAL, 32'd0);

    // auto-reload, prescale 1, irq
    wr("t3.clr", O_STAT, 32'd1);
    wr("t3.psc", O_PSC, 32'd1);
    wr("t3.load", O_LOAD, 32'd2);
    wr("t3.ctrl", O_CTRL, 32'h7);
    for (int i = 0; i < 7; i++) begin
      rd($sformatf("t3.v%0d", i), O_VAL, t3_val[i]);
      chk_irq($sformatf("t3.irq%0d", i), t3_irq[i]);
    end
    wr("t3.w1c", O_STAT, 32'd1);
    chk_irq("t3.irq_pre_clr", 1'b1);
    rd("t3.stat_clr", O_STAT, 32'd0);
    chk_irq("t3.irq_clr", 1'b0);
    wr("t3.stop", O_CTRL, 32'd0);

    // error cases: no state change, read data 0
    wr("e.load", O_LOAD, 32'h1122_3344);
    acc("e.wr_value", 1'b1, 1'b0, BASE + O_VAL, SZ_W, 32'hFFFF_FFFF, 32'd0, 1'b1);
    acc("e.rd_mis", 1'b0, 1'b1, BASE + 32'h2, SZ_W, 32'd0, 32'd0, 1'b1);
    acc("e.wr_14", 1'b1, 1'b0, BASE + 32'h14, SZ_W, 32'd1, 32'd0, 1'b1);
    acc("e.rd_14", 1'b0, 1'b1, BASE + 32'h14, SZ_W, 32'd0, 32'd0, 1'b1);
    acc("e.wr_base", 1'b1, 1'b0, 32'h5000_0004, SZ_W, 32'd0, 32'd0, 1'b1);
    acc("e.rd_base", 1'b0, 1'b1, 32'h5000_0000, SZ_W, 32'd0, 32'd0, 1'b1);
    acc("e.size11", 1'b1, 1'b0, BASE + O_LOAD, SZ_X, 32'd0, 32'd0, 1'b1);
    acc("e.half_odd", 1'b1, 1'b0, BASE + 32'h5, SZ_H, 32'hFFFF_FFFF, 32'd0, 1'b1);
    rd("e.load_kept", O_LOAD, 32'h1122_3344);
    rd("e.val_kept", O_VAL, 32'h1122_3344);
    rd("e.ctrl_kept", O_CTRL, 32'd0);

    // byte / halfword lanes
    acc("b.wr", 1'b1, 1'b0, BASE + 32'h5, SZ_B, 32'h0000_AB00, 32'd0, 1'b0);
    rd("b.load", O_LOAD, 32'h1122_AB44);
    rd("b.val", O_VAL, 32'h1122_AB44);
    acc("h.wr", 1'b1, 1'b0, BASE + 32'h6, SZ_H, 32'h5566_0000, 32'd0, 1'b0);
    acc("h.rd_byte", 1'b0, 1'b1, BASE + 32'h4, SZ_B, 32'd0, 32'h5566_AB44, 1'b0);

    // CTRL write clearing EN discards the tick; LOAD write beats a tick
    wr("d.psc", O_PSC, 32'd0);
    wr("d.load", O_LOAD, 32'd5);
    wr("d.ctrl", O_CTRL, 32'h1);
    rd("d.v5", O_VAL, 32'd5);
    wr("d.stop", O_CTRL, 32'd0);
    rd("d.v4", O_VAL, 32'd4);
    rd("d.v4b", O_VAL, 32'd4);
    wr("l.ctrl", O_CTRL, 32'h1);
    rd("l.v4", O_VAL, 32'd4);
    wr("l.load", O_LOAD, 32'd9);
    rd("l.v9", O_VAL, 32'd9);
    wr("l.stop", O_CTRL, 32'd0);

    // expiry coincides with W1C: set wins
    wr("s.load", O_LOAD, 32'd1);
    wr("s.ctrl", O_CTRL, 32'h1);
    rd("s.v1", O_VAL, 32'd1);
    wr("s.w1c", O_STAT, 32'd1);
    rd("s.stat", O_STAT, 32'd1);
    rd("s.ctrl", O_CTRL, 32'd0);

    // reset mid-count
    wr("r.clr", O_STAT, 32'd1);
    wr("r.load0", O_LOAD, 32'd0);
    wr("r.ctrl", O_CTRL, 32'h7);
    idle(1);
    rd("r.stat", O_STAT, 32'd1);
    chk_irq("r.irq_on", 1'b1);
    wr("r.load", O_LOAD, 32'd50);
    rd("r.v50", O_VAL, 32'd50);
    @(negedge HCLK);
    peripheral_we = 1'b0;
    peripheral_re = 1'b1;
    Addr          = BASE + O_LOAD;
    size          = SZ_W;
    #2;
    HRESET = 1'b1;
    #1;
    chk_irq("r.irq_async", 1'b0);
    check_val("r.rd_async", peripheral_rd_data, 32'd0);
    check_val("r.resp_async", {31'd0, peripheral_response}, 32'd0);
    check_val("r.ready_async", {31'd0, peripheral_ready}, 32'd1);
    @(negedge HCLK);
    peripheral_we = 1'b1;
    Addr          = 32'h5000_0000;
    #1;
    check_val("r.resp_in_rst", {31'd0, peripheral_response}, 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    idle(1);
    for (int i = 0; i < 5; i++) rd($sformatf("r.reg%0d", i), off_tab[i], 32'd0);
    chk_irq("r.irq_after", 1'b0);
    rd("r.v_still0", O_VAL, 32'd0);

    // random legal reads of PRESCALE after random writes
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      d = $urandom_range(0, 32'h7FFF_FFFF);
      wr($sformatf("p.wr%0d", i), O_PSC, d);
      rd($sformatf("p.rd%0d", i), O_PSC, {16'd0, d[15:0]});
    end

    idle(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
